// File: rtl/bus_interconnect_mp.sv
// Multi-master simple-bus interconnect: round-robin arbitration, address decode onto
// one-hot slave strobes, decode-error responses and a saturating error counter.
module bus_interconnect_mp #(
  parameter int                           NUM_MASTERS = 2,
  parameter int                           NUM_SLAVES  = 8,
  parameter int                           DATA_W      = 32,
  parameter logic [NUM_SLAVES-1:0][31:0]  SLAVE_BASE  = '0,
  parameter logic [NUM_SLAVES-1:0][31:0]  SLAVE_MASK  = {NUM_SLAVES{32'hFFFF_F000}},
  parameter logic [DATA_W-1:0]            ERR_RDATA   = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_MASTERS-1:0]                  m_valid,
  input  logic [NUM_MASTERS-1:0]                  m_write,
  input  logic [NUM_MASTERS-1:0][31:0]            m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]      m_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]    m_wstrb,
  output logic [NUM_MASTERS-1:0]                  m_ready,
  output logic [NUM_MASTERS-1:0]                  m_rvalid,
  output logic [DATA_W-1:0]                       m_rdata,
  output logic [NUM_MASTERS-1:0]                  m_err,
  output logic [NUM_SLAVES-1:0]                   s_req_valid,
  output logic                                    s_req_write,
  output logic [31:0]                             s_req_addr,
  output logic [DATA_W-1:0]                       s_req_wdata,
  output logic [DATA_W/8-1:0]                     s_req_wstrb,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0]       s_rdata,
  output logic [NUM_SLAVES-1:0]                   s_resp_read_pulse,
  output logic [31:0]                             s_resp_addr,
  output logic [15:0]                             err_count
);
  // state  | meaning
  // IDLE   | arbitrate; grant edge registers m_ready / s_req_* for the ISSUE cycle
  // ISSUE  | request strobe on the slave port; reads capture slave data at its end
  // RESP   | read data (or ERR_RDATA) returned to the granted master

  localparam int STRB_W = DATA_W / 8;
  localparam int MW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
  state_t state_q, state_d;

  logic [MW-1:0]          rr_ptr, grant_idx, arb_cand, grant_q;
  logic                   grant_any;
  logic [31:0]            win_addr, addr_q;
  logic                   dec_hit, hit_q, wr_q;
  logic [SW-1:0]          dec_slave, slave_q;

  logic [NUM_MASTERS-1:0] m_ready_d, m_rvalid_d, m_err_d;
  logic [NUM_SLAVES-1:0]  s_req_valid_d, s_resp_read_pulse_d;
  logic [DATA_W-1:0]      m_rdata_d, s_req_wdata_d;
  logic [STRB_W-1:0]      s_req_wstrb_d;
  logic [31:0]            s_req_addr_d, s_resp_addr_d;
  logic                   s_req_write_d;
  logic [15:0]            err_count_d;

  // Round-robin search starting at rr_ptr; first requesting master wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    arb_cand  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      arb_cand = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!grant_any && m_valid[arb_cand]) begin
        grant_any = 1'b1;
        grant_idx = arb_cand;
      end
    end
  end

  // Descending scan so the lowest matching region index overrides on overlap.
  always_comb begin
    win_addr  = m_addr[grant_idx];
    dec_hit   = 1'b0;
    dec_slave = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((win_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        dec_hit   = 1'b1;
        dec_slave = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any) state_d = S_ISSUE;
      S_ISSUE: state_d = wr_q ? S_IDLE : S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      grant_q <= '0;
      slave_q <= '0;
      hit_q   <= 1'b0;
      rr_ptr  <= '0;
    end else if (state_q == S_IDLE && grant_any) begin
      wr_q    <= m_write[grant_idx];
      addr_q  <= win_addr;
      grant_q <= grant_idx;
      slave_q <= dec_slave;
      hit_q   <= dec_hit;
      rr_ptr  <= MW'((int'(grant_idx) + 1) % NUM_MASTERS);
    end
  end

  // Next values for the registered outputs; pulses default low, data fields hold.
  always_comb begin
    m_ready_d           = '0;
    m_rvalid_d          = '0;
    m_err_d             = '0;
    s_req_valid_d       = '0;
    s_resp_read_pulse_d = '0;
    m_rdata_d           = m_rdata;
    s_resp_addr_d       = s_resp_addr;
    err_count_d         = err_count;
    s_req_write_d       = s_req_write;
    s_req_addr_d        = s_req_addr;
    s_req_wdata_d       = s_req_wdata;
    s_req_wstrb_d       = s_req_wstrb;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          m_ready_d[grant_idx] = 1'b1;
          s_req_write_d        = m_write[grant_idx];
          s_req_addr_d         = win_addr;
          s_req_wdata_d        = m_wdata[grant_idx];
          s_req_wstrb_d        = m_wstrb[grant_idx];
          if (dec_hit) begin
            s_req_valid_d[dec_slave] = 1'b1;
          end else begin
            m_err_d[grant_idx] = 1'b1;
            if (err_count != 16'hFFFF) err_count_d = err_count + 16'd1;
          end
        end
      end
      S_ISSUE: begin
        if (!wr_q) begin
          m_rvalid_d[grant_q] = 1'b1;
          if (hit_q) begin
            m_rdata_d                    = s_rdata[slave_q];
            s_resp_read_pulse_d[slave_q] = 1'b1;
            s_resp_addr_d                = addr_q;
          end else begin
            m_rdata_d        = ERR_RDATA;
            m_err_d[grant_q] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ready           <= '0;
      m_rvalid          <= '0;
      m_err             <= '0;
      s_req_valid       <= '0;
      s_resp_read_pulse <= '0;
      m_rdata           <= '0;
      s_resp_addr       <= '0;
      err_count         <= '0;
      s_req_write       <= 1'b0;
      s_req_addr        <= '0;
      s_req_wdata       <= '0;
      s_req_wstrb       <= '0;
    end else begin
      m_ready           <= m_ready_d;
      m_rvalid          <= m_rvalid_d;
      m_err             <= m_err_d;
      s_req_valid       <= s_req_valid_d;
      s_resp_read_pulse <= s_resp_read_pulse_d;
      m_rdata           <= m_rdata_d;
      s_resp_addr       <= s_resp_addr_d;
      err_count         <= err_count_d;
      s_req_write       <= s_req_write_d;
      s_req_addr        <= s_req_addr_d;
      s_req_wdata       <= s_req_wdata_d;
      s_req_wstrb       <= s_req_wstrb_d;
    end
  end

endmodule

// File: tb/tb_bus_interconnect_mp.sv
// Scenario bench for bus_interconnect_mp: two masters, three 4 KiB slave regions.
module tb_bus_interconnect_mp;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]          m_valid, m_write, m_ready, m_rvalid, m_err;
  logic [NM-1:0][31:0]    m_addr;
  logic [NM-1:0][DW-1:0]  m_wdata;
  logic [NM-1:0][3:0]     m_wstrb;
  logic [DW-1:0]          m_rdata;
  logic [NS-1:0]          s_req_valid, s_resp_read_pulse;
  logic                   s_req_write;
  logic [31:0]            s_req_addr, s_resp_addr;
  logic [DW-1:0]          s_req_wdata;
  logic [3:0]             s_req_wstrb;
  logic [NS-1:0][DW-1:0]  s_rdata;
  logic [15:0]            err_count;

  bus_interconnect_mp #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .DATA_W(DW),
    .SLAVE_BASE({32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLAVE_MASK({3{32'hFFFF_F000}}),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req_valid(s_req_valid), .s_req_write(s_req_write), .s_req_addr(s_req_addr),
    .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb), .s_rdata(s_rdata),
    .s_resp_read_pulse(s_resp_read_pulse), .s_resp_addr(s_resp_addr), .err_count(err_count)
  );

  typedef struct {
    logic [NS-1:0] sv;
    logic [NM-1:0] gnt;
    logic          err;
    logic [31:0]   addr;
    logic [31:0]   rdata;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; m_valid = '0; m_write = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata[0] = 32'h0000_AAAA; s_rdata[1] = 32'h1234_5678; s_rdata[2] = 32'h2222_0002;
    repeat (3) @(negedge clk);
    total++; if (m_ready !== '0) begin bad++; $display("FAIL reset_m_ready: got %b want 00", m_ready); end
    total++; if (m_rvalid !== '0) begin bad++; $display("FAIL reset_m_rvalid: got %b want 00", m_rvalid); end
    total++; if (m_err !== '0) begin bad++; $display("FAIL reset_m_err: got %b want 00", m_err); end
    total++; if (s_req_valid !== '0) begin bad++; $display("FAIL reset_s_req_valid: got %b want 000", s_req_valid); end
    total++; if (s_resp_read_pulse !== '0) begin bad++; $display("FAIL reset_resp_pulse: got %b want 000", s_resp_read_pulse); end
    total++; if (m_rdata !== '0) begin bad++; $display("FAIL reset_m_rdata: got %h want 0", m_rdata); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL reset_err_count: got %h want 0", err_count); end
    total++; if ({s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_resp_addr} !== '0) begin
      bad++; $display("FAIL reset_req_fields: got addr %h wdata %h want all 0", s_req_addr, s_req_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    exp_t e;
    m_valid = 2'b01; m_write = 2'b00; m_addr[0] = 32'h1004;
    exp_q.push_back('{sv: 3'b010, gnt: 2'b01, err: 1'b0, addr: 32'h1004, rdata: 32'h1234_5678});
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if (s_req_valid !== e.sv) begin bad++; $display("FAIL rd_s_req_valid: got %b want %b", s_req_valid, e.sv); end
    total++; if (m_ready !== e.gnt) begin bad++; $display("FAIL rd_m_ready: got %b want %b", m_ready, e.gnt); end
    total++; if (s_req_addr !== e.addr || s_req_write !== 1'b0) begin
      bad++; $display("FAIL rd_req_fields: got addr %h wr %b want %h 0", s_req_addr, s_req_write, e.addr);
    end
    total++; if (m_rvalid !== '0) begin bad++; $display("FAIL rd_early_rvalid: got %b want 00", m_rvalid); end
    m_valid = '0;
    @(negedge clk);
    total++; if (m_rvalid !== e.gnt) begin bad++; $display("FAIL rd_m_rvalid: got %b want %b", m_rvalid, e.gnt); end
    total++; if (m_rdata !== e.rdata) begin bad++; $display("FAIL rd_m_rdata: got %h want %h", m_rdata, e.rdata); end
    total++; if (s_resp_read_pulse !== e.sv) begin bad++; $display("FAIL rd_resp_pulse: got %b want %b", s_resp_read_pulse, e.sv); end
    total++; if (s_resp_addr !== e.addr) begin bad++; $display("FAIL rd_resp_addr: got %h want %h", s_resp_addr, e.addr); end
    total++; if (m_ready !== '0 || m_err !== '0) begin bad++; $display("FAIL rd_resp_ready_err: got %b %b want 00 00", m_ready, m_err); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int grants;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_write = 2'b11; m_addr[0] = 32'h0010; m_addr[1] = 32'h2020;
    m_wdata[0] = 32'h1111_0000; m_wdata[1] = 32'h2222_0000; m_wstrb[0] = 4'hF; m_wstrb[1] = 4'hF;
    m_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_q.push_back('{sv: 3'b001, gnt: 2'b01, err: 1'b0, addr: 32'h0010, rdata: 32'h0});
      else            exp_q.push_back('{sv: 3'b100, gnt: 2'b10, err: 1'b0, addr: 32'h2020, rdata: 32'h0});
    end
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge clk);
      if (m_ready !== '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rr_extra_grant: got %b want none", m_ready);
        end else begin
          e = exp_q.pop_front();
          if (m_ready !== e.gnt || s_req_valid !== e.sv || s_req_addr !== e.addr) begin
            bad++; $display("FAIL rr_grant%0d: got rdy %b sv %b addr %h want %b %b %h",
                            grants, m_ready, s_req_valid, s_req_addr, e.gnt, e.sv, e.addr);
          end
        end
        total++; if (c != 2 * grants) begin bad++; $display("FAIL rr_spacing%0d: got cycle %0d want %0d", grants, c, 2 * grants); end
        grants++;
        if (grants == 4) m_valid = '0;
      end
    end
    total++; if (grants != 4) begin bad++; $display("FAIL rr_timeout: got %0d grants want 4", grants); end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] addrs[2];
    logic [31:0] datas[2];
    logic [3:0]  strbs[2];
    logic [NS-1:0] svs[2];
    int          mst[2];
    exp_t e;
    addrs = '{32'h2008, 32'h0040}; datas = '{32'hA5A5_A5A5, 32'h5A5A_0F0F};
    strbs = '{4'b0011, 4'b0000};   svs = '{3'b100, 3'b001};  mst = '{1, 0};
    for (int t = 0; t < 2; t++) begin
      m_write = 2'b11; m_addr[mst[t]] = addrs[t]; m_wdata[mst[t]] = datas[t]; m_wstrb[mst[t]] = strbs[t];
      m_valid = '0; m_valid[mst[t]] = 1'b1;
      exp_q.push_back('{sv: svs[t], gnt: m_valid, err: 1'b0, addr: addrs[t], rdata: 32'h0});
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (s_req_valid !== e.sv) begin bad++; $display("FAIL wr%0d_s_req_valid: got %b want %b", t, s_req_valid, e.sv); end
      total++; if (m_ready !== e.gnt || m_err !== '0) begin bad++; $display("FAIL wr%0d_ready: got %b err %b want %b 00", t, m_ready, m_err, e.gnt); end
      total++; if (s_req_write !== 1'b1 || s_req_addr !== e.addr || s_req_wdata !== datas[t] || s_req_wstrb !== strbs[t]) begin
        bad++; $display("FAIL wr%0d_fields: got %b %h %h %b want 1 %h %h %b", t, s_req_write, s_req_addr,
                        s_req_wdata, s_req_wstrb, e.addr, datas[t], strbs[t]);
      end
      m_valid = '0;
      @(negedge clk);
      total++; if (m_rvalid !== '0 || m_ready !== '0 || s_req_valid !== '0) begin
        bad++; $display("FAIL wr%0d_after: got rvalid %b ready %b sv %b want all 0", t, m_rvalid, m_ready, s_req_valid);
      end
    end
  endtask

  task automatic test_decode_error();
    exp_t e;
    m_valid = 2'b01; m_write = 2'b00; m_addr[0] = 32'h8000;
    exp_q.push_back('{sv: 3'b000, gnt: 2'b01, err: 1'b1, addr: 32'h8000, rdata: 32'hDEAD_BEEF});
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if (s_req_valid !== e.sv) begin bad++; $display("FAIL de_s_req_valid: got %b want %b", s_req_valid, e.sv); end
    total++; if (m_ready !== e.gnt || m_err !== e.gnt) begin bad++; $display("FAIL de_ready_err: got %b %b want %b %b", m_ready, m_err, e.gnt, e.gnt); end
    m_valid = '0;
    @(negedge clk);
    total++; if (m_rvalid !== e.gnt || m_err !== e.gnt) begin bad++; $display("FAIL de_rvalid_err: got %b %b want %b %b", m_rvalid, m_err, e.gnt, e.gnt); end
    total++; if (m_rdata !== e.rdata) begin bad++; $display("FAIL de_m_rdata: got %h want %h", m_rdata, e.rdata); end
    total++; if (s_resp_read_pulse !== '0) begin bad++; $display("FAIL de_resp_pulse: got %b want 000", s_resp_read_pulse); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL de_err_count: got %h want 0001", err_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    exp_t e;
    m_valid = 2'b01; m_write = 2'b00; m_addr[0] = 32'h1004;
    @(negedge clk);
    total++; if (m_ready !== 2'b01) begin bad++; $display("FAIL mr_issue_ready: got %b want 01", m_ready); end
    rst = 1'b1; m_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    total++; if (m_rvalid !== '0 || m_ready !== '0 || m_err !== '0) begin
      bad++; $display("FAIL mr_handshake: got rvalid %b ready %b err %b want all 0", m_rvalid, m_ready, m_err);
    end
    total++; if (s_req_valid !== '0 || s_resp_read_pulse !== '0) begin bad++; $display("FAIL mr_strobes: got %b %b want 0 0", s_req_valid, s_resp_read_pulse); end
    total++; if (m_rdata !== '0 || s_resp_addr !== '0 || s_req_addr !== '0 || err_count !== '0) begin
      bad++; $display("FAIL mr_data_zero: got rdata %h raddr %h qaddr %h cnt %h want all 0", m_rdata, s_resp_addr, s_req_addr, err_count);
    end
    m_valid = 2'b10; m_write = 2'b00; m_addr[1] = 32'h0008;
    exp_q.push_back('{sv: 3'b001, gnt: 2'b10, err: 1'b0, addr: 32'h0008, rdata: 32'h0000_AAAA});
    @(negedge clk);
    e = exp_q.pop_front();
    total++; if (m_ready !== e.gnt || s_req_valid !== e.sv) begin bad++; $display("FAIL mr_m1_grant: got %b %b want %b %b", m_ready, s_req_valid, e.gnt, e.sv); end
    m_valid = '0;
    @(negedge clk);
    total++; if (m_rvalid !== e.gnt || m_rdata !== e.rdata) begin bad++; $display("FAIL mr_m1_rdata: got %b %h want %b %h", m_rvalid, m_rdata, e.gnt, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [15:0] model;
    force dut.err_count = 16'hFFFC;
    repeat (2) @(negedge clk);
    release dut.err_count;
    @(negedge clk);
    model = 16'hFFFC;
    total++; if (err_count !== model) begin bad++; $display("FAIL sat_preload: got %h want %h", err_count, model); end
    for (int k = 0; k < 5; k++) begin
      m_valid = 2'b01; m_write = 2'b01; m_addr[0] = 32'h9000;
      @(negedge clk);
      total++; if (m_err !== 2'b01) begin bad++; $display("FAIL sat_err%0d: got %b want 01", k, m_err); end
      m_valid = '0;
      @(negedge clk);
      model = (model == 16'hFFFF) ? 16'hFFFF : model + 16'd1;
      total++; if (err_count !== model) begin bad++; $display("FAIL sat_count%0d: got %h want %h", k, err_count, model); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_decode_error();
    test_reset_mid_read();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
